// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the data-cache stall controller: FSM state encoding
// and the width of the performance counters.
package stall_ctrl_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] REFILL  = 2'd2;
    localparam logic [1:0] WR_THRU = 2'd3;

    localparam int PERF_W = 32;

endpackage

// File: rtl/stall_latency_counter.sv
// Load / decrement down-counter that times main-memory accesses.
// It saturates at zero rather than wrapping.
module stall_latency_counter
    import stall_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/cache_stall_controller.sv
// Sequences data-cache read misses and write-through stores, driving the pipeline stall.
// Optional performance counters are built when STALL_CTRL_PERF_EN is defined.
module cache_stall_controller
    import stall_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        cache_hit,
    output logic        stall,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic        refill_en,
    output logic        busy,
    output logic [31:0] perf_rd_miss,
    output logic [31:0] perf_wr_cnt,
    output logic [31:0] perf_stall
);

    localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(RD_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] WR_LOAD = CNT_WIDTH'(WR_LATENCY - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 done;
    logic                 done_nxt;
    logic                 start_wr;
    logic                 start_rd;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic [CNT_WIDTH-1:0] cnt_val;
    logic                 cnt_zero;

    // RST gates the Mealy starts so stall reads 0 for the whole reset window.
    assign start_wr = !RST && (state == IDLE) && mem_write && !done;
    assign start_rd = !RST && (state == IDLE) && mem_read && !cache_hit && !mem_write && !done;

    stall_latency_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_lat_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start_wr) begin
                    state_nxt = WR_THRU;
                    cnt_load  = 1'b1;
                    cnt_val   = WR_LOAD;
                end else if (start_rd) begin
                    state_nxt = RD_MISS;
                    cnt_load  = 1'b1;
                    cnt_val   = RD_LOAD;
                end
            end
            RD_MISS: begin
                if (cnt_zero) begin
                    state_nxt = REFILL;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            REFILL: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            WR_THRU: begin
                // done holds off the still-present store for one cycle so the pipeline advances.
                if (cnt_zero) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall     = start_wr || start_rd || (state != IDLE);
        mem_rd_en = (state == RD_MISS);
        mem_wr_en = (state == WR_THRU);
        refill_en = (state == REFILL);
        busy      = (state != IDLE);
    end

`ifdef STALL_CTRL_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_rd_miss <= '0;
            perf_wr_cnt  <= '0;
            perf_stall   <= '0;
        end else begin
            perf_rd_miss <= sat_inc(perf_rd_miss, start_rd);
            perf_wr_cnt  <= sat_inc(perf_wr_cnt, start_wr);
            perf_stall   <= sat_inc(perf_stall, stall);
        end
    end
`else
    assign perf_rd_miss = '0;
    assign perf_wr_cnt  = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_cache_stall_controller.sv
// Bench for cache_stall_controller: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with random resets.
module tb_cache_stall_controller;

    localparam int RD_L = 4;
    localparam int WR_L = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        cache_hit = 1'b0;
    logic        stall, mem_rd_en, mem_wr_en, refill_en, busy;
    logic [31:0] perf_rd_miss, perf_wr_cnt, perf_stall;

    int pass_cnt = 0;
    int total_cnt = 0;

    cache_stall_controller #(
        .RD_LATENCY(RD_L),
        .WR_LATENCY(WR_L),
        .CNT_WIDTH (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .cache_hit    (cache_hit),
        .stall        (stall),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .refill_en    (refill_en),
        .busy         (busy),
        .perf_rd_miss (perf_rd_miss),
        .perf_wr_cnt  (perf_wr_cnt),
        .perf_stall   (perf_stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    // Reference model: an operation in flight is tracked by its elapsed cycle k (1-based,
    // the detect cycle is k=0); after it ends the same instruction is ignored for one cycle.
    bit          m_active = 0;
    bit          m_kind = 0;     // 0 = read miss, 1 = store
    int          m_k = 0;
    bit          m_blocked = 0;
    int unsigned m_rd = 0, m_wr = 0, m_st = 0;

    function automatic bit trig();
        return !m_active && !m_blocked && (mem_write || (mem_read && !cache_hit));
    endfunction

    function automatic int op_len();
        return m_kind ? WR_L : RD_L + 1;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_active  <= 0;
            m_blocked <= 0;
            m_k       <= 0;
            m_rd      <= 0;
            m_wr      <= 0;
            m_st      <= 0;
        end else begin
            if (m_active || trig()) m_st <= m_st + 1;
            if (m_active) begin
                if (m_k >= op_len()) begin
                    m_active  <= 0;
                    m_blocked <= 1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (trig()) begin
                m_active  <= 1;
                m_k       <= 1;
                m_kind    <= mem_write;
                m_blocked <= 0;
                if (mem_write) m_wr <= m_wr + 1;
                else m_rd <= m_rd + 1;
            end else begin
                m_blocked <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        logic e_stall, e_rd, e_wr, e_ref, e_busy;
        logic [31:0] e_prd, e_pwr, e_pst;
        e_stall = 0; e_rd = 0; e_wr = 0; e_ref = 0; e_busy = 0;
        e_prd = 0; e_pwr = 0; e_pst = 0;
        if (!RST) begin
            if (m_active) begin
                e_stall = 1;
                e_busy  = 1;
                e_wr    = m_kind;
                e_rd    = !m_kind && (m_k <= RD_L);
                e_ref   = !m_kind && (m_k == RD_L + 1);
            end else begin
                e_stall = trig();
            end
`ifdef STALL_CTRL_PERF_EN
            e_prd = m_rd;
            e_pwr = m_wr;
            e_pst = m_st;
`endif
        end
        check("model_stall", {31'b0, stall}, {31'b0, e_stall});
        check("model_busy", {31'b0, busy}, {31'b0, e_busy});
        check("model_mem_rd_en", {31'b0, mem_rd_en}, {31'b0, e_rd});
        check("model_mem_wr_en", {31'b0, mem_wr_en}, {31'b0, e_wr});
        check("model_refill_en", {31'b0, refill_en}, {31'b0, e_ref});
        check("model_perf_rd_miss", perf_rd_miss, e_prd);
        check("model_perf_wr_cnt", perf_wr_cnt, e_pwr);
        check("model_perf_stall", perf_stall, e_pst);
    end

    task automatic step(input logic r, input logic w, input logic h, input logic rs);
        @(posedge CLK);
        #1;
        mem_read  = r;
        mem_write = w;
        cache_hit = h;
        RST       = rs;
        @(negedge CLK);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_perf_stall", perf_stall, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Read miss: stall cycles 0-5, mem_rd_en 1-4, refill 5, hit from 6.
        step(1, 0, 0, 0);
        check("rd_c0_stall", {31'b0, stall}, 32'd1);
        check("rd_c0_rd_en", {31'b0, mem_rd_en}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0);
            check("rd_rd_en", {31'b0, mem_rd_en}, 32'd1);
            check("rd_stall", {31'b0, stall}, 32'd1);
        end
        step(1, 0, 0, 0);
        check("rd_c5_refill", {31'b0, refill_en}, 32'd1);
        check("rd_c5_stall", {31'b0, stall}, 32'd1);
        step(1, 0, 1, 0);
        check("rd_c6_stall", {31'b0, stall}, 32'd0);
        check("rd_c6_refill", {31'b0, refill_en}, 32'd0);
        step(0, 0, 0, 0);

        // Store with hit: stall 0-4, mem_wr_en 1-4, cycle 5 blocked by done.
        step(0, 1, 1, 0);
        check("wr_c0_stall", {31'b0, stall}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 1, 0);
            check("wr_wr_en", {31'b0, mem_wr_en}, 32'd1);
            check("wr_stall", {31'b0, stall}, 32'd1);
        end
        step(0, 1, 1, 0);
        check("wr_c5_stall", {31'b0, stall}, 32'd0);
        check("wr_c5_wr_en", {31'b0, mem_wr_en}, 32'd0);
        step(0, 0, 0, 0);

`ifdef STALL_CTRL_PERF_EN
        check("perf_rd_miss_lit", perf_rd_miss, 32'd1);
        check("perf_wr_cnt_lit", perf_wr_cnt, 32'd1);
        check("perf_stall_lit", perf_stall, 32'd11);
`else
        check("perf_rd_miss_off", perf_rd_miss, 32'd0);
        check("perf_wr_cnt_off", perf_wr_cnt, 32'd0);
        check("perf_stall_off", perf_stall, 32'd0);
`endif

        // Read hit for 10 cycles: nothing happens.
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 1, 0);
            check("hit_stall", {31'b0, stall}, 32'd0);
            check("hit_busy", {31'b0, busy}, 32'd0);
        end

        // Load and store together on a miss: store path only.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0);
            check("both_rd_en", {31'b0, mem_rd_en}, 32'd0);
            if (i == 1) check("both_c1_wr_en", {31'b0, mem_wr_en}, 32'd1);
        end
        repeat (6) step(0, 0, 0, 0);

        // Reset in the 2nd RD_MISS cycle aborts the miss; a new one then runs normally.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        step(1, 0, 0, 1);
        check("rst_refill", {31'b0, refill_en}, 32'd0);
        step(1, 0, 0, 0);
        check("rst_new_c0_stall", {31'b0, stall}, 32'd1);
        repeat (4) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_new_c5_refill", {31'b0, refill_en}, 32'd1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic rr, ww, hh, rs;
            rr = ($urandom_range(0, 1) == 1);
            ww = ($urandom_range(0, 3) == 0);
            hh = ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 99) == 0);
            step(rr, ww, hh, rs);
        end
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
